mmc1_mapper: RTL and testbench

Parametrised bank-switching cartridge mapper, the banked successor of the fixed NROM pass-through. It decodes MMC1-style serial register writes from the CPU bus. It remaps CPU and PPU addresses into the PRG/CHR PSRAM address space with switchable PRG and CHR banks. It also drives runtime-selectable nametable mirroring and gates work-RAM enable. It sits between the cartridge-edge pins and the PSRAM/SRAM pins in the top-level FPGA design.

---
 rtl/mmc1_pkg.sv | 28 ++
 rtl/mmc1_serial_port.sv | 79 +++++++
 rtl/mmc1_mapper.sv | 97 +++++++++
 tb/tb_mmc1_mapper.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmc1_pkg.sv
// Shared constants and encodings for the MMC1-style cartridge mapper.
// Register indices follow the CPU address lines A14:A13 of the fifth serial write.
package mmc1_pkg;

  localparam logic [1:0] REG_CONTROL = 2'd0;
  localparam logic [1:0] REG_CHR0    = 2'd1;
  localparam logic [1:0] REG_CHR1    = 2'd2;
  localparam logic [1:0] REG_PRG     = 2'd3;

  typedef enum logic [1:0] {
    MIRROR_ONE_LOW  = 2'd0,
    MIRROR_ONE_HIGH = 2'd1,
    MIRROR_VERT     = 2'd2,
    MIRROR_HORZ     = 2'd3
  } mirror_t;

  typedef enum logic [1:0] {
    PRG_32K_A     = 2'd0,
    PRG_32K_B     = 2'd1,
    PRG_FIX_FIRST = 2'd2,
    PRG_FIX_LAST  = 2'd3
  } prg_mode_t;

  // Bit 4 of the shift register is a marker; it reaches bit 0 after four serial bits.
  localparam logic [4:0] SHIFT_EMPTY = 5'b10000;
  localparam logic [4:0] CONTROL_RST = 5'h0C;

endpackage

// File: rtl/mmc1_serial_port.sv
// Serial register port: synchronises m2, captures CPU writes, and assembles
// five-bit values into the control/CHR/PRG register file.
module mmc1_serial_port
  import mmc1_pkg::*;
(
  input  logic       clk50,
  input  logic       rst,
  input  logic       m2,
  input  logic       cpu_romsel,
  input  logic       cpu_rw,
  input  logic [1:0] reg_sel,
  input  logic [7:0] cpu_d_in,
  output logic [4:0] control,
  output logic [4:0] chr0,
  output logic [4:0] chr1,
  output logic [4:0] prg
);

  logic       m2_q1, m2_s, m2_s_d;
  logic       armed, wr_last;
  logic [7:0] wdata;
  logic [1:0] wsel;
  logic [4:0] shift;
  logic [4:0] value;
  logic       fall;

  assign fall  = m2_s_d & ~m2_s;
  assign value = {wdata[0], shift[4:1]};

  always_ff @(posedge clk50) begin
    if (rst) begin
      m2_q1   <= 1'b0;
      m2_s    <= 1'b0;
      m2_s_d  <= 1'b0;
      armed   <= 1'b0;
      wr_last <= 1'b0;
      wdata   <= '0;
      wsel    <= '0;
      shift   <= SHIFT_EMPTY;
      control <= CONTROL_RST;
      chr0    <= '0;
      chr1    <= '0;
      prg     <= '0;
    end else begin
      m2_q1  <= m2;
      m2_s   <= m2_q1;
      m2_s_d <= m2_s;

      // Keep copying while m2 is high so the value latched is the last one before the fall.
      if (fall) begin
        armed   <= 1'b0;
        wr_last <= armed;
      end else if (m2_s && !cpu_romsel && !cpu_rw) begin
        armed <= 1'b1;
        wdata <= cpu_d_in;
        wsel  <= reg_sel;
      end

      // A write directly following another write (RMW dummy write) is dropped.
      if (fall && armed && !wr_last) begin
        if (wdata[7]) begin
          shift        <= SHIFT_EMPTY;
          control[3:2] <= 2'b11;
        end else if (!shift[0]) begin
          shift <= value;
        end else begin
          shift <= SHIFT_EMPTY;
          unique case (wsel)
            REG_CONTROL: control <= value;
            REG_CHR0:    chr0    <= value;
            REG_CHR1:    chr1    <= value;
            REG_PRG:     prg     <= value;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/mmc1_mapper.sv
// MMC1-style bank-switching mapper: serial register port plus combinational
// PRG/CHR bank remap, nametable mirroring and work-RAM gating.
module mmc1_mapper
  import mmc1_pkg::*;
#(
  parameter int PRG_BANK_BITS = 4,
  parameter int CHR_BANK_BITS = 5
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        m2,
  input  logic [14:0] cpu_a,
  input  logic        cpu_romsel,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_d_in,
  input  logic [13:0] ppu_a,
  output logic [22:0] prg_a,
  output logic        prg_ce,
  output logic        prg_oe,
  output logic [22:0] chr_a,
  output logic        chr_ce,
  output logic        chr_oe,
  output logic        ppu_ciram_ce,
  output logic        ppu_ciram_a10,
  output logic        sram_ce,
  output logic        sram_oe,
  output logic        sram_we,
  output logic        cpu_dir
);

  localparam logic [3:0] PRG_MASK = 4'((1 << PRG_BANK_BITS) - 1);
  localparam logic [4:0] CHR_MASK = 5'((1 << CHR_BANK_BITS) - 1);

  logic [4:0] control, chr0, chr1, prg;
  logic [3:0] prg_bank;
  logic [4:0] chr_bank;
  logic       sram_act;
  prg_mode_t  prg_mode;
  mirror_t    mirror;

  mmc1_serial_port u_port (
    .clk50      (clk50),
    .rst        (rst),
    .m2         (m2),
    .cpu_romsel (cpu_romsel),
    .cpu_rw     (cpu_rw),
    .reg_sel    (cpu_a[14:13]),
    .cpu_d_in   (cpu_d_in),
    .control    (control),
    .chr0       (chr0),
    .chr1       (chr1),
    .prg        (prg)
  );

  assign prg_mode = prg_mode_t'(control[3:2]);
  assign mirror   = mirror_t'(control[1:0]);

  always_comb begin
    prg_bank = '0;
    case (prg_mode)
      PRG_32K_A, PRG_32K_B: prg_bank = {prg[3:1], cpu_a[14]};
      PRG_FIX_FIRST:        prg_bank = cpu_a[14] ? prg[3:0] : 4'h0;
      PRG_FIX_LAST:         prg_bank = cpu_a[14] ? 4'hF : prg[3:0];
    endcase
  end

  always_comb begin
    chr_bank = control[4] ? (ppu_a[12] ? chr1 : chr0) : {chr0[4:1], ppu_a[12]};
  end

  always_comb begin
    ppu_ciram_a10 = 1'b0;
    case (mirror)
      MIRROR_ONE_LOW:  ppu_ciram_a10 = 1'b0;
      MIRROR_ONE_HIGH: ppu_ciram_a10 = 1'b1;
      MIRROR_VERT:     ppu_ciram_a10 = ppu_a[10];
      MIRROR_HORZ:     ppu_ciram_a10 = ppu_a[11];
    endcase
  end

  assign prg_a  = {5'b0, prg_bank & PRG_MASK, cpu_a[13:0]};
  assign prg_ce = cpu_rw ? cpu_romsel : 1'b1;
  assign prg_oe = prg_ce;

  assign chr_a  = {6'b0, chr_bank & CHR_MASK, ppu_a[11:0]};
  assign chr_ce = ppu_a[13];
  assign chr_oe = ppu_a[13];
  assign ppu_ciram_ce = ~ppu_a[13];

  // Work RAM at $6000-$7FFF, disabled by PRG register bit 4.
  assign sram_act = cpu_romsel & (cpu_a[14:13] == 2'b11) & m2 & ~prg[4];
  assign sram_ce  = ~sram_act;
  assign sram_we  = cpu_rw | sram_ce;
  assign sram_oe  = ~cpu_rw | sram_ce;
  assign cpu_dir  = ~cpu_romsel | sram_act;

endmodule

// File: tb/tb_mmc1_mapper.sv
// Self-checking bench for mmc1_mapper: transaction-level register model with a
// per-cycle output compare, plus hand-computed literal checks.
module tb_mmc1_mapper;

  localparam int PBB = 4;
  localparam int CBB = 5;

  logic        clk50 = 1'b0;
  logic        rst, m2, cpu_romsel, cpu_rw;
  logic [14:0] cpu_a;
  logic [7:0]  cpu_d_in;
  logic [13:0] ppu_a;
  logic [22:0] prg_a, chr_a;
  logic        prg_ce, prg_oe, chr_ce, chr_oe, ppu_ciram_ce, ppu_ciram_a10;
  logic        sram_ce, sram_oe, sram_we, cpu_dir;

  mmc1_mapper #(.PRG_BANK_BITS(PBB), .CHR_BANK_BITS(CBB)) dut (
    .clk50(clk50), .rst(rst), .m2(m2), .cpu_a(cpu_a), .cpu_romsel(cpu_romsel),
    .cpu_rw(cpu_rw), .cpu_d_in(cpu_d_in), .ppu_a(ppu_a), .prg_a(prg_a),
    .prg_ce(prg_ce), .prg_oe(prg_oe), .chr_a(chr_a), .chr_ce(chr_ce), .chr_oe(chr_oe),
    .ppu_ciram_ce(ppu_ciram_ce), .ppu_ciram_a10(ppu_ciram_a10), .sram_ce(sram_ce),
    .sram_oe(sram_oe), .sram_we(sram_we), .cpu_dir(cpu_dir)
  );

  always #10 clk50 = ~clk50;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Register model: values the CPU has committed, and pending serial bits.
  int m_control, m_chr0, m_chr1, m_prg;
  int m_cnt;
  int m_bits[5];
  bit m_wr_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_control = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
    m_cnt = 0; m_wr_last = 1'b0;
    for (int i = 0; i < 5; i++) m_bits[i] = 0;
  endfunction

  function automatic void model_fall(input bit is_wr, input int addr, input int data);
    int v;
    if (is_wr) begin
      if (!m_wr_last) begin
        if (data >= 128) begin
          m_cnt = 0;
          m_control = m_control | 12;
        end else begin
          m_bits[m_cnt] = data % 2;
          m_cnt++;
          if (m_cnt == 5) begin
            v = 0;
            for (int i = 0; i < 5; i++) v += m_bits[i] << i;
            case (addr / 8192)
              0: m_control = v;
              1: m_chr0 = v;
              2: m_chr1 = v;
              default: m_prg = v;
            endcase
            m_cnt = 0;
          end
        end
      end
      m_wr_last = 1'b1;
    end else begin
      m_wr_last = 1'b0;
    end
  endfunction

  function automatic int exp_shift();
    int s;
    s = 1 << (4 - m_cnt);
    for (int i = 0; i < m_cnt; i++) s += m_bits[i] << (5 - m_cnt + i);
    return s;
  endfunction

  function automatic int exp_prg_a();
    int hi, b, p;
    hi = (cpu_a / 16384) % 2;
    p = m_prg % 16;
    case ((m_control / 4) % 4)
      0, 1: b = (p / 2) * 2 + hi;
      2: b = hi ? p : 0;
      default: b = hi ? 15 : p;
    endcase
    b = b % (1 << PBB);
    return b * 16384 + (cpu_a % 16384);
  endfunction

  function automatic int exp_chr_a();
    int hi, c;
    hi = (ppu_a / 4096) % 2;
    if (m_control >= 16) c = hi ? m_chr1 : m_chr0;
    else c = (m_chr0 / 2) * 2 + hi;
    c = c % (1 << CBB);
    return c * 4096 + (ppu_a % 4096);
  endfunction

  function automatic int exp_a10();
    case (m_control % 4)
      0: return 0;
      1: return 1;
      2: return (ppu_a / 1024) % 2;
      default: return (ppu_a / 2048) % 2;
    endcase
  endfunction

  always @(negedge clk50) begin
    if (chk_en) begin
      bit act, a13;
      act = cpu_romsel && (cpu_a / 8192 == 3) && m2 && (m_prg < 16);
      a13 = ppu_a[13];
      check("prg_a", 32'(prg_a), exp_prg_a());
      check("prg_ce", 32'(prg_ce), cpu_rw ? 32'(cpu_romsel) : 32'd1);
      check("prg_oe", 32'(prg_oe), cpu_rw ? 32'(cpu_romsel) : 32'd1);
      check("chr_a", 32'(chr_a), exp_chr_a());
      check("chr_ce", 32'(chr_ce), 32'(a13));
      check("chr_oe", 32'(chr_oe), 32'(a13));
      check("ciram_ce", 32'(ppu_ciram_ce), 32'(!a13));
      check("ciram_a10", 32'(ppu_ciram_a10), exp_a10());
      check("sram_ce", 32'(sram_ce), 32'(!act));
      check("sram_we", 32'(sram_we), 32'(cpu_rw || !act));
      check("sram_oe", 32'(sram_oe), 32'(!cpu_rw || !act));
      check("cpu_dir", 32'(cpu_dir), 32'(!cpu_romsel || act));
    end
  end

  task automatic do_reset();
    @(posedge clk50); #1;
    chk_en = 1'b0; rst = 1'b1; m2 = 1'b0;
    repeat (3) @(posedge clk50);
    #1 rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
  endtask

  task automatic bus_cycle(input logic [14:0] a, input logic romsel, input logic rw, input logic [7:0] d);
    @(posedge clk50); #1;
    cpu_a = a; cpu_romsel = romsel; cpu_rw = rw; cpu_d_in = d;
    repeat (2) @(posedge clk50);
    #1 m2 = 1'b1;
    repeat (6) @(posedge clk50);
    #1 chk_en = 1'b0; m2 = 1'b0;
    repeat (6) @(posedge clk50);
    #1 model_fall(!romsel && !rw, int'(a), int'(d));
    chk_en = 1'b1;
  endtask

  task automatic idle_cycle();
    bus_cycle(15'h0000, 1'b1, 1'b1, 8'h00);
  endtask

  task automatic write_bit(input logic [14:0] a, input logic b);
    bus_cycle(a, 1'b0, 1'b0, {7'b0, b});
    idle_cycle();
  endtask

  task automatic serial_write(input logic [14:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) write_bit(a, v[i]);
  endtask

  task automatic set_bus(input logic [14:0] a, input logic romsel, input logic rw, input logic [13:0] pa);
    @(posedge clk50); #1;
    cpu_a = a; cpu_romsel = romsel; cpu_rw = rw; ppu_a = pa;
    @(negedge clk50);
  endtask

  task automatic sweep();
    for (int i = 0; i < 12; i++)
      set_bus(15'($urandom), 1'($urandom), 1'($urandom), 14'($urandom));
  endtask

  initial begin
    rst = 1'b1; m2 = 1'b0; cpu_a = '0; cpu_romsel = 1'b1; cpu_rw = 1'b1;
    cpu_d_in = '0; ppu_a = '0;
    model_reset();
    do_reset();

    set_bus(15'h7FFC, 1'b0, 1'b1, 14'h0000);
    check("rst_prg_a_last_bank", 32'(prg_a), 32'h03FFFC);
    check("rst_prg_ce", 32'(prg_ce), 32'd0);
    set_bus(15'h0000, 1'b0, 1'b1, 14'h0000);
    check("rst_prg_a_zero", 32'(prg_a), 32'h0);
    check("rst_shift", 32'(dut.u_port.shift), 32'h10);
    sweep();

    serial_write(15'h6000, 5'd2);
    set_bus(15'h0123, 1'b0, 1'b1, 14'h0000);
    check("prg2_prg_a", 32'(prg_a), 32'h008123);
    sweep();

    write_bit(15'h0000, 1'b1);
    write_bit(15'h0000, 1'b0);
    write_bit(15'h0000, 1'b1);
    check("partial_shift", 32'(dut.u_port.shift), 32'(exp_shift()));
    bus_cycle(15'h0000, 1'b0, 1'b0, 8'h80);
    idle_cycle();
    check("abort_shift", 32'(dut.u_port.shift), 32'h10);
    check("abort_control", 32'(dut.u_port.control), 32'h0C);
    serial_write(15'h4000, 5'd7);
    serial_write(15'h0000, 5'h12);
    set_bus(15'h0000, 1'b1, 1'b1, 14'h1ABC);
    check("chr1_chr_a", 32'(chr_a), 32'h007ABC);
    set_bus(15'h0000, 1'b1, 1'b1, 14'h2400);
    check("vert_a10", 32'(ppu_ciram_a10), 32'd1);
    check("nt_chr_ce", 32'(chr_ce), 32'd1);
    sweep();

    // RMW pattern: second of two consecutive writes must be dropped.
    bus_cycle(15'h6000, 1'b0, 1'b0, 8'h01);
    bus_cycle(15'h6000, 1'b0, 1'b0, 8'h00);
    idle_cycle();
    check("rmw_shift", 32'(dut.u_port.shift), 32'h18);
    check("rmw_shift_model", 32'(dut.u_port.shift), 32'(exp_shift()));
    write_bit(15'h6000, 1'b0);
    write_bit(15'h6000, 1'b0);
    write_bit(15'h6000, 1'b0);
    write_bit(15'h6000, 1'b1);
    check("rmw_prg", 32'(dut.u_port.prg), 32'h11);

    set_bus(15'h6000, 1'b1, 1'b1, 14'h0000);
    #1 m2 = 1'b1;
    @(negedge clk50);
    check("wram_off_ce", 32'(sram_ce), 32'd1);
    chk_en = 1'b0;
    #1 m2 = 1'b0;
    repeat (6) @(posedge clk50);
    #1 model_fall(1'b0, 0, 0);
    chk_en = 1'b1;
    serial_write(15'h6000, 5'h02);
    set_bus(15'h6000, 1'b1, 1'b1, 14'h0000);
    #1 m2 = 1'b1;
    @(negedge clk50);
    check("wram_on_ce", 32'(sram_ce), 32'd0);
    check("wram_on_oe", 32'(sram_oe), 32'd0);
    chk_en = 1'b0;
    #1 m2 = 1'b0;
    repeat (6) @(posedge clk50);
    #1 model_fall(1'b0, 0, 0);
    chk_en = 1'b1;

    // Fifth-bit commit carrying bit 7 resolves as a reset write.
    serial_write(15'h2000, 5'h15);
    for (int i = 0; i < 4; i++) write_bit(15'h2000, 1'b1);
    bus_cycle(15'h2000, 1'b0, 1'b0, 8'h81);
    idle_cycle();
    check("bit7_dom_shift", 32'(dut.u_port.shift), 32'h10);
    check("bit7_dom_control", 32'(dut.u_port.control), 32'h1E);
    check("bit7_dom_chr0", 32'(dut.u_port.chr0), 32'h15);
    sweep();

    serial_write(15'h6000, 5'h0B);
    serial_write(15'h0000, 5'h00);
    sweep();
    serial_write(15'h0000, 5'h09);
    sweep();
    serial_write(15'h0000, 5'h0B);
    sweep();
    serial_write(15'h0000, 5'h1F);
    sweep();

    // Reset mid-sequence discards the partial shift.
    write_bit(15'h2000, 1'b1);
    write_bit(15'h2000, 1'b1);
    do_reset();
    check("midrst_shift", 32'(dut.u_port.shift), 32'h10);
    check("midrst_control", 32'(dut.u_port.control), 32'h0C);
    sweep();
    serial_write(15'h2000, 5'h03);
    sweep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
